// File: rtl/p2_sprite_renderer.sv
// Player-2 sprite reader: box test, bitmap ROM addressing, pixel select and animation sequencer.
// Optional build macro BBOX_DEBUG_EN adds a perimeter overlay and a dbg_state output.
module p2_sprite_renderer #(
  parameter int SCALE_LOG2 = 1,
  parameter int FRAME_DIV  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [2:0]  action_req,
  input  logic        facing_req,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_bitmap,
  output logic        sprite_pixel,
  output logic        anim_done,
  output logic        busy
`ifdef BBOX_DEBUG_EN
  ,
  output logic        dbg_state
`endif
);

  localparam logic [10:0] BOX_SIZE = 11'(32'd16 << SCALE_LOG2);
  localparam logic [5:0]  DIV_LAST = 6'(FRAME_DIV - 1);

  typedef enum logic [0:0] {
    ST_LOOP    = 1'b0,
    ST_ONESHOT = 1'b1
  } state_t;

  // Codes 5-7 are not real actions and fall back to "stay".
  function automatic logic [2:0] sanitize_action(input logic [2:0] a);
    logic [2:0] r;
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: r = a;
      default:                      r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic is_oneshot(input logic [2:0] a);
    return (a == 3'd3) || (a == 3'd4);
  endfunction

  state_t      state_r, state_nx_s;
  logic [1:0]  frame_r, frame_nx_s;
  logic [5:0]  div_r, div_nx_s;
  logic [2:0]  act_r, act_nx_s, req_act_s;
  logic        face_r, face_nx_s;
  logic        busy_nx_s, done_nx_s;

  logic [10:0] dx_s, dy_s;
  logic        in_box_s;
  logic [3:0]  col_s, row_s, bitidx_s;
  logic        in_box_d1_r, in_box_d2_r;
  logic [3:0]  col_d1_r, col_d2_r;
  logic        pix_nx_s;

`ifdef BBOX_DEBUG_EN
  logic        perim_s, perim_d1_r, perim_d2_r;
  assign dbg_state = (state_r == ST_ONESHOT);
`endif

  assign req_act_s = sanitize_action(action_req);

  // Animation sequencer next-state: only frame_start moves it.
  always_comb begin
    state_nx_s = state_r;
    frame_nx_s = frame_r;
    div_nx_s   = div_r;
    act_nx_s   = act_r;
    face_nx_s  = face_r;
    busy_nx_s  = busy;
    done_nx_s  = 1'b0;
    if (frame_start) begin
      face_nx_s = facing_req;
      case (state_r)
        ST_LOOP: begin
          act_nx_s = req_act_s;
          if (is_oneshot(req_act_s)) begin
            state_nx_s = ST_ONESHOT;
            frame_nx_s = 2'd0;
            div_nx_s   = 6'd0;
            busy_nx_s  = 1'b1;
          end else if (req_act_s != act_r) begin
            frame_nx_s = 2'd0;
            div_nx_s   = 6'd0;
          end else if (div_r == DIV_LAST) begin
            div_nx_s   = 6'd0;
            frame_nx_s = frame_r + 2'd1;
          end else begin
            div_nx_s   = div_r + 6'd1;
          end
        end
        ST_ONESHOT: begin
          // action_req is ignored here until the last frame has been shown
          if (div_r == DIV_LAST) begin
            div_nx_s = 6'd0;
            if (frame_r == 2'd3) begin
              state_nx_s = ST_LOOP;
              frame_nx_s = 2'd0;
              busy_nx_s  = 1'b0;
              done_nx_s  = 1'b1;
              act_nx_s   = req_act_s;
            end else begin
              frame_nx_s = frame_r + 2'd1;
            end
          end else begin
            div_nx_s = div_r + 6'd1;
          end
        end
        default: begin
          state_nx_s = ST_LOOP;
          frame_nx_s = 2'd0;
          div_nx_s   = 6'd0;
          busy_nx_s  = 1'b0;
        end
      endcase
    end else begin
      done_nx_s = 1'b0;
    end
  end

  // Animation sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_LOOP;
      frame_r   <= 2'd0;
      div_r     <= 6'd0;
      act_r     <= 3'd0;
      face_r    <= 1'b0;
      busy      <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      frame_r   <= frame_nx_s;
      div_r     <= div_nx_s;
      act_r     <= act_nx_s;
      face_r    <= face_nx_s;
      busy      <= busy_nx_s;
      anim_done <= done_nx_s;
    end
  end

  // Negative offsets set bit 10, so they can never pass the size compare.
  assign dx_s     = {1'b0, pixel_x} - {1'b0, sprite_x};
  assign dy_s     = {1'b0, pixel_y} - {1'b0, sprite_y};
  assign in_box_s = video_on && !dx_s[10] && !dy_s[10] && (dx_s < BOX_SIZE) && (dy_s < BOX_SIZE);
  assign col_s    = 4'(dx_s >> SCALE_LOG2);
  assign row_s    = 4'(dy_s >> SCALE_LOG2);
  assign bitidx_s = face_r ? col_d2_r : (4'd15 - col_d2_r);

`ifdef BBOX_DEBUG_EN
  assign perim_s  = in_box_s && ((row_s == 4'd0) || (row_s == 4'd15) || (col_s == 4'd0) || (col_s == 4'd15));
  assign pix_nx_s = in_box_d2_r && (!rom_bitmap[bitidx_s] || perim_d2_r);
`else
  assign pix_nx_s = in_box_d2_r && !rom_bitmap[bitidx_s];
`endif

  // Pixel pipeline aligned to the ROM's one-cycle registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr     <= 10'd0;
      in_box_d1_r  <= 1'b0;
      in_box_d2_r  <= 1'b0;
      col_d1_r     <= 4'd0;
      col_d2_r     <= 4'd0;
      sprite_pixel <= 1'b0;
`ifdef BBOX_DEBUG_EN
      perim_d1_r   <= 1'b0;
      perim_d2_r   <= 1'b0;
`endif
    end else begin
      if (in_box_s) begin
        rom_addr <= {row_s, act_r, 1'b0, frame_r};
      end
      in_box_d1_r  <= in_box_s;
      in_box_d2_r  <= in_box_d1_r;
      col_d1_r     <= col_s;
      col_d2_r     <= col_d1_r;
      sprite_pixel <= pix_nx_s;
`ifdef BBOX_DEBUG_EN
      perim_d1_r   <= perim_s;
      perim_d2_r   <= perim_d1_r;
`endif
    end
  end

endmodule

// File: tb/tb_p2_sprite_renderer.sv
// Directed bench for p2_sprite_renderer: two instances (unscaled/FRAME_DIV=2, scaled/FRAME_DIV=1)
// share stimulus, each backed by a small registered ROM model.
module tb_p2_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst, video_on, frame_start, facing_req;
  logic [9:0]  pixel_x, pixel_y, sprite_x, sprite_y;
  logic [2:0]  action_req;
  logic [15:0] bm_a, bm_b;
  logic [9:0]  addr_a, addr_b;
  logic        pix_a, pix_b, done_a, done_b, busy_a, busy_b;
`ifdef BBOX_DEBUG_EN
  logic        dbg_a, dbg_b;
`endif

  int tests = 0;
  int fails = 0;

  logic [9:0] cap_addr_a, cap_addr_b;
  logic       cap_early_a, cap_pix_a, cap_pix_b;
  logic [1:0] exp_f [8];

  always #5 clk = ~clk;

  // Row 0 is 1111110000111111; every other row is fully opaque.
  function automatic logic [15:0] rom_row(input logic [9:0] a);
    logic [15:0] r;
    if (a[9:6] == 4'd0) r = 16'hFC3F;
    else                r = 16'h0000;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    bm_a <= rom_row(addr_a);
    bm_b <= rom_row(addr_b);
  end

  p2_sprite_renderer #(.SCALE_LOG2(0), .FRAME_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .action_req(action_req), .facing_req(facing_req), .rom_addr(addr_a),
    .rom_bitmap(bm_a), .sprite_pixel(pix_a), .anim_done(done_a), .busy(busy_a)
`ifdef BBOX_DEBUG_EN
    , .dbg_state(dbg_a)
`endif
  );

  p2_sprite_renderer #(.SCALE_LOG2(1), .FRAME_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .action_req(action_req), .facing_req(facing_req), .rom_addr(addr_b),
    .rom_bitmap(bm_b), .sprite_pixel(pix_b), .anim_done(done_b), .busy(busy_b)
`ifdef BBOX_DEBUG_EN
    , .dbg_state(dbg_b)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One in-box pixel for a single cycle, then two idle cycles to see it emerge.
  task automatic probe(input logic [9:0] x, input logic [9:0] y);
    pixel_x  = x;
    pixel_y  = y;
    video_on = 1'b1;
    tick();
    cap_addr_a = addr_a;
    cap_addr_b = addr_b;
    video_on   = 1'b0;
    tick();
    cap_early_a = pix_a;
    tick();
    cap_pix_a = pix_a;
    cap_pix_b = pix_b;
  endtask

  initial begin
    exp_f = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    rst = 1'b1; video_on = 1'b0; frame_start = 1'b0; facing_req = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; sprite_x = 10'd100; sprite_y = 10'd200;
    action_req = 3'd0;
    tick();
    tick();
    chk("rst_addr", 16'(addr_a), 16'd0);
    chk("rst_pix", 16'(pix_a), 16'd0);
    chk("rst_done", 16'(done_a), 16'd0);
    chk("rst_busy", 16'(busy_a), 16'd0);
    rst = 1'b0;

    // Addressing, normal facing
    probe(10'd106, 10'd200);
    chk("addr_106", 16'(cap_addr_a), 16'o0000);
    chk("lat_k1", 16'(cap_early_a), 16'd0);
    chk("pix_106", 16'(cap_pix_a), 16'd1);
    probe(10'd100, 10'd200);
    chk("pix_100", 16'(cap_pix_a), 16'd0);
    probe(10'd103, 10'd205);
    chk("addr_row5", 16'(cap_addr_a), 16'o0500);
    chk("pix_row5", 16'(cap_pix_a), 16'd1);
    probe(10'd115, 10'd215);
    chk("addr_corner", 16'(cap_addr_a), 16'o1700);
    chk("pix_corner", 16'(cap_pix_a), 16'd1);
    probe(10'd116, 10'd200);
    chk("pix_right_out", 16'(cap_pix_a), 16'd0);
    chk("addr_hold", 16'(cap_addr_a), 16'o1700);

    // Scaling on the SCALE_LOG2=1 instance
    probe(10'd131, 10'd231);
    chk("addr_scaled", 16'(cap_addr_b), 16'o1700);
    chk("pix_scaled", 16'(cap_pix_b), 16'd1);
    probe(10'd132, 10'd200);
    chk("pix_scaled_out", 16'(cap_pix_b), 16'd0);
    chk("addr_scaled_hold", 16'(cap_addr_b), 16'o1700);
    probe(10'd99, 10'd200);
    chk("pix_left_out", 16'(cap_pix_b), 16'd0);

    // Mirroring
    facing_req = 1'b1;
    pulse();
    probe(10'd100, 10'd200);
    chk("mir_pix_100", 16'(cap_pix_a), 16'd0);
    chk("mir_addr", 16'(cap_addr_a), 16'o0000);
    probe(10'd109, 10'd200);
    chk("mir_pix_109", 16'(cap_pix_a), 16'd1);

    // Looping forward action with FRAME_DIV=2
    do_reset();
    facing_req = 1'b0;
    action_req = 3'd1;
    pulse();
    for (int i = 0; i < 8; i++) begin
      pulse();
      probe(10'd100, 10'd200);
      chk($sformatf("loop%0d", i), 16'(cap_addr_a), 16'o0010 + 16'(exp_f[i]));
    end
    pulse();
    pulse();
    pulse();
    action_req = 3'd2;
    pulse();
    probe(10'd100, 10'd200);
    chk("act_change", 16'(cap_addr_a), 16'o0020);
    action_req = 3'd6;
    pulse();
    probe(10'd100, 10'd201);
    chk("invalid_act", 16'(cap_addr_a), 16'o0100);

    // One-shot punch on the FRAME_DIV=1 instance
    do_reset();
    action_req = 3'd3;
    tick();
    chk("busy_prelatch", 16'(busy_b), 16'd0);
    pulse();
    chk("busy_rise", 16'(busy_b), 16'd1);
    chk("done_entry", 16'(done_b), 16'd0);
    action_req = 3'd4;
    probe(10'd100, 10'd200);
    chk("os_addr0", 16'(cap_addr_b), 16'o0030);
    for (int i = 1; i < 4; i++) begin
      pulse();
      chk($sformatf("os_busy%0d", i), 16'(busy_b), 16'd1);
      chk($sformatf("os_done%0d", i), 16'(done_b), 16'd0);
    end
    probe(10'd100, 10'd200);
    chk("os_addr3", 16'(cap_addr_b), 16'o0033);
    action_req = 3'd1;
    pulse();
    chk("os_done_pulse", 16'(done_b), 16'd1);
    chk("os_busy_fall", 16'(busy_b), 16'd0);
    tick();
    chk("os_done_clear", 16'(done_b), 16'd0);
    probe(10'd100, 10'd200);
    chk("os_relatch", 16'(cap_addr_b), 16'o0010);

    // Reset mid-line while streaming opaque pixels and a one-shot is playing
    do_reset();
    action_req = 3'd3;
    pulse();
    chk("rs_busy", 16'(busy_a), 16'd1);
    pixel_x  = 10'd103;
    pixel_y  = 10'd205;
    video_on = 1'b1;
    tick();
    tick();
    tick();
    chk("rs_stream_pix", 16'(pix_a), 16'd1);
    chk("rs_stream_addr", 16'(addr_a), 16'o0530);
    rst = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rs_addr", 16'(addr_a), 16'd0);
    chk("rs_pix", 16'(pix_a), 16'd0);
    chk("rs_busy0", 16'(busy_a), 16'd0);
    chk("rs_done0", 16'(done_a), 16'd0);
    rst = 1'b0;
    tick();
    chk("rs_flush1", 16'(pix_a), 16'd0);
    tick();
    chk("rs_flush2", 16'(pix_a), 16'd0);
    tick();
    chk("rs_resume", 16'(pix_a), 16'd1);
    chk("rs_resume_addr", 16'(addr_a), 16'o0500);
    video_on = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p2_sprite_renderer.md
Name: p2_sprite_renderer

Overview:
- Reader side of the player-2 sprite bitmap ROM (16x16 poses, 1-bit rows, registered address, 1-cycle read latency).
- Per VGA pixel, computes the ROM address {row[3:0], action[2:0], frame[2:0]} and selects one bit of the returned row. Outputs an opaque/transparent flag to the colour mixer.
- Owns the animation sequencer: frame index stepping, looping vs one-shot actions, and frame-boundary latching of action/facing.

Parameters:
- SCALE_LOG2, 1, on-screen pixel replication; sprite occupies (16<<SCALE_LOG2) square pixels.
- FRAME_DIV, 6, video frames per animation step (1..63).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- pixel_x  in  10  current VGA column.
- pixel_y  in  10  current VGA row.
- video_on  in  1  visible-area flag.
- frame_start  in  1  one-cycle pulse at start of each video frame.
- sprite_x  in  10  left edge of the sprite box.
- sprite_y  in  10  top edge of the sprite box.
- action_req  in  3  0 stay, 1 forward, 2 backward, 3 punch, 4 kick; 5-7 are treated as 0.
- facing_req  in  1  0 normal, 1 horizontally mirrored.
- rom_addr  out  10  address to the bitmap ROM.
- rom_bitmap  in  16  ROM row data, valid one edge after rom_addr is sampled by the ROM.
- sprite_pixel  out  1  1 = opaque sprite pixel.
- anim_done  out  1  one-cycle pulse when a one-shot action completes.
- busy  out  1  1 while a one-shot action is playing.

Behaviour:
- Reset values: rom_addr=0, sprite_pixel=0, anim_done=0, busy=0, internal frame=0, divider=0, state=LOOP, latched action=0, latched facing=0.
- Latching: action and facing are latched only on a frame_start pulse, so no mid-frame tearing. Exception: while in ONESHOT, action_req is ignored until completion.
- Box test:
  - dx = pixel_x - sprite_x and dy = pixel_y - sprite_y, computed in 11 bits.
  - in_box = video_on and 0<=dx<16<<SCALE_LOG2 and 0<=dy<16<<SCALE_LOG2, with no wrap at screen edges.
  - col = dx>>SCALE_LOG2 and row = dy>>SCALE_LOG2, each 4 bits.
- Pipeline, inputs sampled at edge k:
  - Edge k: rom_addr <= {row, action, 1'b0, frame[1:0]}. in_box and col are delayed into stage 1.
  - Edge k+1: the ROM registers the address. in_box and col are delayed into stage 2.
  - Edge k+2: sprite_pixel <= in_box_d2 and (rom_bitmap[bitidx]==0).
  - bitidx = 15-col_d2 when facing=0, col_d2 when facing=1.
  - Total latency: 2 edges. Outside the box, rom_addr keeps its last value and sprite_pixel is 0.
- Animation FSM, stepped only on frame_start:
  - LOOP (actions 0-2): divider counts 0..FRAME_DIV-1. On wrap, frame <= frame+1 mod 4.
  - LOOP -> ONESHOT when a latched action is 3 or 4. Entry sets frame=0, divider=0, busy=1.
  - ONESHOT: steps frames 0,1,2,3 at the same rate. When the step would pass frame 3, pulse anim_done for one cycle, set busy=0, frame=0, go to LOOP, and latch the current action_req on that same frame_start.
  - A change of latched action within LOOP resets frame and divider to 0.
  - Simultaneous frame_start and rst: rst wins.
- Reset mid-frame: the pipeline is flushed, so sprite_pixel=0 for 2 cycles after rst deasserts regardless of position.

Optional Feature:
- BBOX_DEBUG_EN defined:
  - sprite_pixel is forced to 1 on the box perimeter (row or col equal to 0 or 15 in sprite coordinates), pipelined with identical latency.
  - An extra output dbg_state (1 bit, 0=LOOP, 1=ONESHOT) is added.
- Undefined: no perimeter override and no extra port.

Test Plan:
- Addressing and mirroring, with SCALE_LOG2=0, sprite at (100,200), action 0, frame 0, bitmap row 0 = 1111110000111111:
  - Normal facing: pixel (106,200) -> rom_addr=10'o0000, sprite_pixel=1 two edges later. Pixel (100,200) -> 0.
  - facing_req=1 latched: pixel (100,200) -> 0. Pixel (109,200) -> 1.
- Scaling, with SCALE_LOG2=1, sprite at (100,200): pixel (131,231) -> rom_addr=10'o1700. Pixel (132,200) -> out of box, sprite_pixel=0.
- Looping, with FRAME_DIV=2 and action 1: frame_start pulses 1..8 -> frame sequence 0,1,1,2,2,3,3,0. Address low digit matches, e.g. 10'o0013 at frame 3.
- One-shot, with action_req=3 and FRAME_DIV=1:
  - busy rises at the latching frame_start. anim_done pulses exactly once after 4 steps, then returns to LOOP.
  - Changing action_req to 4 during play has no effect until done.
- Invalid action and reset:
  - action_req=6 -> address action digit 0.
  - rst asserted mid-line -> all outputs 0 next edge. sprite_pixel stays 0 for 2 edges after release.
